rpc2_ctrl_reg_burst_logic: RTL

//  Next-generation AXI-slave register access engine for the controller register file.

---
 rtl/rpc2_ctrl_reg_burst_logic_if.sv | 46 ++++
 rtl/rpc2_ctrl_reg_burst_logic.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rpc2_ctrl_reg_burst_logic_if.sv
// Bundle of the axi2ip request/data/response channels and the register-file strobes
// between an AXI slave front end and the register burst engine.
interface rpc2_ctrl_reg_burst_logic_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  axi2ip_valid;
  logic                  ip_ready;
  logic                  axi2ip_rw_n;
  logic [31:0]           axi2ip_address;
  logic [1:0]            axi2ip_burst;
  logic [2:0]            axi2ip_size;
  logic [7:0]            axi2ip_len;
  logic                  axi2ip_data_valid;
  logic                  ip_data_ready;
  logic [STRB_W-1:0]     axi2ip_strb;
  logic                  ip_data_valid;
  logic                  axi2ip_data_ready;
  logic [DATA_WIDTH-1:0] ip_data;
  logic                  ip_data_last;
  logic [STRB_W-1:0]     ip_strb;
  logic [1:0]            ip_rd_error;
  logic                  ip_wr_done;
  logic                  axi2ip_wr_resp_ready;
  logic [1:0]            ip_wr_error;
  logic                  reg_rd_en;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic [STRB_W-1:0]     reg_wr_en;
  logic [REG_ADDR_W-1:0] reg_addr;

  modport master (
    output axi2ip_valid, axi2ip_rw_n, axi2ip_address, axi2ip_burst, axi2ip_size, axi2ip_len,
           axi2ip_data_valid, axi2ip_strb, axi2ip_data_ready, axi2ip_wr_resp_ready, reg_rdata,
    input  ip_ready, ip_data_ready, ip_data_valid, ip_data, ip_data_last, ip_strb, ip_rd_error,
           ip_wr_done, ip_wr_error, reg_rd_en, reg_wr_en, reg_addr
  );

  modport slave (
    input  axi2ip_valid, axi2ip_rw_n, axi2ip_address, axi2ip_burst, axi2ip_size, axi2ip_len,
           axi2ip_data_valid, axi2ip_strb, axi2ip_data_ready, axi2ip_wr_resp_ready, reg_rdata,
    output ip_ready, ip_data_ready, ip_data_valid, ip_data, ip_data_last, ip_strb, ip_rd_error,
           ip_wr_done, ip_wr_error, reg_rd_en, reg_wr_en, reg_addr
  );
endinterface

// File: rtl/rpc2_ctrl_reg_burst_logic.sv
// Register access engine: turns axi2ip FIXED/INCR/WRAP bursts into register strobes, with a
// credit-controlled read buffer that absorbs the register read latency under backpressure.
module rpc2_ctrl_reg_burst_logic #(
  parameter logic [31:0] C_AXI_REG_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_AXI_REG_HIGHADDR = 32'h0000_004B,
  parameter int          DATA_WIDTH         = 32,
  parameter int          REG_ADDR_W         = 5,
  parameter int          RD_LATENCY         = 1
) (
  input logic clk,
  input logic reset_n,
  rpc2_ctrl_reg_burst_logic_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ALSB   = $clog2(STRB_W);
  localparam int DEPTH  = RD_LATENCY + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = 3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_RD_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_WR_RESP  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [2:0]            state_q, state_d;
  logic [7:0]            len_q, beat_q, ret_q;
  logic [1:0]            burst_q, err_q, req_err;
  logic [REG_ADDR_W-1:0] addr_q, addr_next, addr_inc, wrap_mask;
  logic [RD_LATENCY-1:0] pipe_q;
  logic [CNT_W-1:0]      infl_q, fifo_cnt_q;
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [31:0]           addr_off;

  logic accept, issue, rd_en, wr_hs, push, pop, credit_ok, last_beat, rd_valid, ok_burst;

  assign accept    = (state_q == S_IDLE) && bus.axi2ip_valid;
  assign rd_valid  = (fifo_cnt_q != '0);
  assign pop       = rd_valid && bus.axi2ip_data_ready;
  assign push      = pipe_q[RD_LATENCY-1];
  // A beat leaving the buffer this cycle frees its slot for a new read in the same cycle.
  assign credit_ok = (({1'b0, fifo_cnt_q} + {1'b0, infl_q} - {{CNT_W{1'b0}}, pop}) < 4'(DEPTH));
  assign issue     = (state_q == S_READ) && credit_ok;
  assign ok_burst  = (err_q == RESP_OKAY);
  assign rd_en     = issue && ok_burst;
  assign wr_hs     = (state_q == S_WRITE) && bus.axi2ip_data_valid;
  assign last_beat = (ret_q == len_q);
  assign addr_off  = bus.axi2ip_address - C_AXI_REG_BASEADDR;

  always_comb begin
    req_err = RESP_OKAY;
    if (addr_off > (C_AXI_REG_HIGHADDR - C_AXI_REG_BASEADDR)) begin
      req_err = RESP_DECERR;
    end else if ((bus.axi2ip_burst == 2'b11) || (bus.axi2ip_size != 3'(ALSB)) ||
                 ((bus.axi2ip_burst == 2'b10) &&
                  !(bus.axi2ip_len inside {8'd1, 8'd3, 8'd7, 8'd15}))) begin
      req_err = RESP_SLVERR;
    end
  end

  // WRAP lengths are 2^n-1, so len itself is the mask of the wrapping index bits.
  assign wrap_mask = REG_ADDR_W'(len_q);
  assign addr_inc  = addr_q + REG_ADDR_W'(1);
  always_comb begin
    case (burst_q)
      2'b01:   addr_next = addr_inc;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = bus.axi2ip_rw_n ? S_READ : S_WRITE;
      S_READ:     if (issue && (beat_q == len_q)) state_d = S_RD_DRAIN;
      S_RD_DRAIN: if (pop && last_beat) state_d = S_IDLE;
      S_WRITE:    if (wr_hs && (beat_q == len_q)) state_d = S_WR_RESP;
      S_WR_RESP:  if (bus.axi2ip_wr_resp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      burst_q <= '0;
      err_q   <= RESP_OKAY;
      addr_q  <= '0;
      beat_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q   <= bus.axi2ip_len;
        burst_q <= bus.axi2ip_burst;
        err_q   <= req_err;
        addr_q  <= bus.axi2ip_address[ALSB +: REG_ADDR_W];
        beat_q  <= '0;
        ret_q   <= '0;
      end else begin
        if (issue || wr_hs) beat_q <= beat_q + 8'd1;
        if (rd_en || wr_hs) addr_q <= addr_next;
        if (pop)            ret_q  <= ret_q + 8'd1;
      end
    end
  end

  // Error bursts still walk the latency pipe so their zero beats keep order and credit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q     <= '0;
      infl_q     <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      pipe_q <= RD_LATENCY'({pipe_q, issue});
      case ({issue, push})
        2'b10:   infl_q <= infl_q + CNT_W'(1);
        2'b01:   infl_q <= infl_q - CNT_W'(1);
        default: infl_q <= infl_q;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (push) wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ok_burst ? bus.reg_rdata : '0;
  end

  assign bus.ip_ready      = (state_q == S_IDLE);
  assign bus.ip_data_valid = rd_valid;
  assign bus.ip_data       = rd_valid ? mem_q[rptr_q] : '0;
  assign bus.ip_data_last  = rd_valid && last_beat;
  assign bus.ip_strb       = '1;
  assign bus.ip_rd_error   = rd_valid ? err_q : RESP_OKAY;
  assign bus.ip_data_ready = (state_q == S_WRITE);
  assign bus.ip_wr_done    = (state_q == S_WR_RESP);
  assign bus.ip_wr_error   = (state_q == S_WR_RESP) ? err_q : RESP_OKAY;
  assign bus.reg_rd_en     = rd_en;
  assign bus.reg_wr_en     = (wr_hs && ok_burst) ? bus.axi2ip_strb : '0;
  assign bus.reg_addr      = addr_q;
endmodule
